// File: rtl/fetch_controller_if.sv
// Instruction-memory fetch port: one request channel, one response channel.
// The controller drives req/addr; the memory drives ready/valid/rdata.
interface fetch_controller_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic        valid;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  ready,
        input  valid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ready,
        output valid,
        output rdata
    );
endinterface

// File: rtl/fetch_controller.sv
// IF-stage sequencer: selects the next PC, issues single-outstanding fetches,
// buffers one instruction for decode and drains stale fetches after a redirect.
module fetch_controller #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned TIMEOUT      = 16
) (
    input  logic                      clk,
    input  logic                      start,
    input  logic [31:0]               pc,
    output logic [31:0]               pc_next,
    output logic                      pc_stall,
    fetch_controller_if.master        imem,
    output logic                      if_valid,
    output logic [31:0]               if_instr,
    output logic [31:0]               if_pc,
    input  logic                      id_stall,
    input  logic                      br_redirect,
    input  logic [31:0]               br_target,
    input  logic                      trap,
    input  logic [31:0]               trap_vector,
    output logic                      fetch_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        BOOT,
        ISSUE,
        WAIT,
        DRAIN
    } state_t;

    state_t        state;
    logic [31:0]   req_pc;
    logic [CW-1:0] wait_cnt;

    logic          redirect;
    logic [31:0]   redir_pc;
    logic          buf_free;
    logic          accept;

    always_comb begin
        redirect = (trap || br_redirect) && (state != BOOT);
        redir_pc = (trap ? trap_vector : br_target) & ~32'd3;
        buf_free = !if_valid || !id_stall;
        imem.req  = (state == ISSUE) && buf_free && !redirect;
        imem.addr = pc;
        accept   = imem.req && imem.ready;
        pc_next  = pc;
        pc_stall = 1'b1;
        unique case (1'b1)
            (state == BOOT): begin
                pc_next  = RESET_VECTOR;
                pc_stall = 1'b0;
            end
            redirect: begin
                pc_next  = redir_pc;
                pc_stall = 1'b0;
            end
            accept: begin
                pc_next  = pc + 32'd4;
                pc_stall = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            state     <= BOOT;
            if_valid  <= 1'b0;
            if_instr  <= 32'h0000_0013;
            if_pc     <= 32'h0;
            req_pc    <= 32'h0;
            wait_cnt  <= '0;
            fetch_err <= 1'b0;
        end else begin
            if (if_valid && !id_stall)
                if_valid <= 1'b0;
            unique case (state)
                BOOT: state <= ISSUE;
                ISSUE: begin
                    if (accept) begin
                        req_pc <= pc;
                        state  <= WAIT;
                    end
                end
                WAIT, DRAIN: begin
                    // the counter tracks one outstanding fetch, so it
                    // keeps running when a redirect turns WAIT into DRAIN
                    if (imem.valid) begin
                        state    <= ISSUE;
                        wait_cnt <= '0;
                        if (state == WAIT && !redirect) begin
                            if_instr <= imem.rdata;
                            if_pc    <= req_pc;
                            if_valid <= 1'b1;
                        end
                    end else begin
                        if (redirect)
                            state <= DRAIN;
                        if (wait_cnt != TMO)
                            wait_cnt <= wait_cnt + CW'(1);
                    end
                    if (wait_cnt == TMO)
                        fetch_err <= 1'b1;
                end
                default: state <= BOOT;
            endcase
            if (redirect)
                if_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed checks of boot, fetch, stall, redirect, wrap and timeout, then a
// randomized run against an in-order instruction-stream reference model.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        start;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        pc_stall;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_stall;
    logic        br_redirect;
    logic [31:0] br_target;
    logic        trap;
    logic [31:0] trap_vector;
    logic        fetch_err;

    int tests = 0;
    int fails = 0;

    logic [31:0] a;
    logic [31:0] exp_pc;
    logic [31:0] exp_fetch;
    logic [31:0] oaddr;
    logic [31:0] tgt;
    int          lat;
    bit          outst;
    bit          redir;
    int          consumed;

    always #5 clk = ~clk;

    fetch_controller_if imem();

    fetch_controller #(
        .RESET_VECTOR(32'h0000_0000),
        .TIMEOUT     (16)
    ) dut (
        .clk        (clk),
        .start      (start),
        .pc         (pc),
        .pc_next    (pc_next),
        .pc_stall   (pc_stall),
        .imem       (imem),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .id_stall   (id_stall),
        .br_redirect(br_redirect),
        .br_target  (br_target),
        .trap       (trap),
        .trap_vector(trap_vector),
        .fetch_err  (fetch_err)
    );

    function automatic logic [31:0] memv(input logic [31:0] addr);
        return addr ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // behaves as the PC register: hold on stall, else take pc_next
    task automatic adv();
        logic [31:0] n;
        n = pc_stall ? pc : pc_next;
        @(posedge clk);
        #1;
        pc = n;
    endtask

    initial begin
        start       = 1'b0;
        pc          = 32'h1234_5670;
        id_stall    = 1'b0;
        br_redirect = 1'b0;
        trap        = 1'b0;
        br_target   = 32'h0;
        trap_vector = 32'h0;
        imem.ready  = 1'b0;
        imem.valid  = 1'b0;
        imem.rdata  = 32'h0;

        repeat (3) @(posedge clk);
        settle();
        chk("rst_if_valid", if_valid, 0);
        chk("rst_if_instr", if_instr, 32'h0000_0013);
        chk("rst_if_pc", if_pc, 0);
        chk("rst_fetch_err", fetch_err, 0);
        @(posedge clk);
        #1;
        start = 1'b1;

        settle();
        chk("boot_pc_next", pc_next, 32'h0);
        chk("boot_stall", pc_stall, 0);
        chk("boot_req", imem.req, 0);
        adv();

        imem.ready = 1'b1;
        settle();
        chk("issue0_req", imem.req, 1);
        chk("issue0_addr", imem.addr, 32'h0);
        chk("issue0_next", pc_next, 32'h4);
        chk("issue0_stall", pc_stall, 0);
        adv();

        for (int k = 0; k < 3; k++) begin
            a = 32'(k * 4);
            imem.valid = 1'b1;
            imem.rdata = memv(a);
            settle();
            chk("wait_req", imem.req, 0);
            chk("wait_stall", pc_stall, 1);
            adv();
            imem.valid = 1'b0;
            if (k == 2) begin
                id_stall = 1'b1;
                repeat (3) begin
                    settle();
                    chk("hold_if_pc", if_pc, a);
                    chk("hold_if_instr", if_instr, memv(a));
                    chk("hold_req", imem.req, 0);
                    chk("hold_stall", pc_stall, 1);
                    adv();
                end
                id_stall = 1'b0;
            end
            settle();
            chk("seq_if_valid", if_valid, 1);
            chk("seq_if_pc", if_pc, a);
            chk("seq_if_instr", if_instr, memv(a));
            chk("seq_req", imem.req, 1);
            chk("seq_addr", imem.addr, a + 32'd4);
            adv();
        end

        br_redirect = 1'b1;
        br_target   = 32'h100;
        settle();
        chk("redir_next", pc_next, 32'h100);
        chk("redir_stall", pc_stall, 0);
        chk("redir_req", imem.req, 0);
        adv();
        br_redirect = 1'b0;
        imem.valid  = 1'b1;
        imem.rdata  = memv(32'hC);
        settle();
        chk("drain_req", imem.req, 0);
        adv();
        imem.valid = 1'b0;
        imem.ready = 1'b0;
        settle();
        chk("drop_if_valid", if_valid, 0);
        chk("after_drain_req", imem.req, 1);
        chk("after_drain_addr", imem.addr, 32'h100);
        chk("noaccept_stall", pc_stall, 1);
        adv();

        trap        = 1'b1;
        trap_vector = 32'h80;
        br_redirect = 1'b1;
        br_target   = 32'h203;
        settle();
        chk("prio_trap", pc_next, 32'h80);
        chk("prio_req", imem.req, 0);
        adv();
        trap = 1'b0;
        settle();
        chk("br_align", pc_next, 32'h200);
        adv();

        br_target = 32'hFFFF_FFFC;
        settle();
        adv();
        br_redirect = 1'b0;
        imem.ready  = 1'b1;
        settle();
        chk("wrap_addr", imem.addr, 32'hFFFF_FFFC);
        chk("wrap_next", pc_next, 32'h0);
        adv();
        imem.ready = 1'b0;
        repeat (15) begin
            settle();
            adv();
        end
        settle();
        chk("tmo_early", fetch_err, 0);
        adv();
        repeat (4) begin
            settle();
            adv();
        end
        settle();
        chk("tmo_set", fetch_err, 1);
        chk("tmo_req", imem.req, 0);
        adv();
        imem.valid = 1'b1;
        imem.rdata = memv(32'hFFFF_FFFC);
        settle();
        adv();
        imem.valid = 1'b0;
        settle();
        chk("tmo_sticky", fetch_err, 1);
        chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);

        start = 1'b0;
        #1;
        chk("rst2_fetch_err", fetch_err, 0);
        chk("rst2_if_valid", if_valid, 0);
        @(posedge clk);
        #1;
        start = 1'b1;
        pc    = 32'h0BAD_0000;
        settle();
        adv();

        exp_pc    = 32'h0;
        exp_fetch = 32'h0;
        outst     = 1'b0;
        lat       = 0;
        consumed  = 0;
        for (int c = 0; c < 1500; c++) begin
            imem.valid = 1'b0;
            if (outst) begin
                if (lat == 0) begin
                    imem.valid = 1'b1;
                    imem.rdata = memv(oaddr);
                    outst      = 1'b0;
                end else begin
                    lat--;
                end
            end
            imem.ready = ($urandom_range(0, 9) < 7);
            id_stall   = ($urandom_range(0, 3) == 0);
            if (imem.valid && if_valid)
                id_stall = 1'b0;
            redir       = ($urandom_range(0, 19) == 0);
            trap        = 1'b0;
            br_redirect = 1'b0;
            if (redir) begin
                trap        = 1'($urandom_range(0, 1));
                br_redirect = !trap || ($urandom_range(0, 1) == 1);
                trap_vector = $urandom;
                br_target   = $urandom;
                tgt = (trap ? trap_vector : br_target) & 32'hFFFF_FFFC;
            end
            settle();
            if (redir) begin
                chk("rnd_redir_next", pc_next, tgt);
                chk("rnd_redir_req", imem.req, 0);
                exp_pc    = tgt;
                exp_fetch = tgt;
            end else begin
                if (if_valid && !id_stall) begin
                    chk("rnd_if_pc", if_pc, exp_pc);
                    chk("rnd_if_instr", if_instr, memv(exp_pc));
                    exp_pc = exp_pc + 32'd4;
                    consumed++;
                end
                if (imem.req && imem.ready) begin
                    chk("rnd_fetch_addr", imem.addr, exp_fetch);
                    exp_fetch = exp_fetch + 32'd4;
                    oaddr     = imem.addr;
                    outst     = 1'b1;
                    lat       = $urandom_range(0, 2);
                end
            end
            adv();
        end
        trap        = 1'b0;
        br_redirect = 1'b0;
        settle();
        chk("rnd_progress", 32'(consumed > 50), 1);
        chk("rnd_no_err", fetch_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
